dmem_bus_arbiter: RTL and testbench

Arbitrates the single-port data memory between two requesters: the CPU load/store port (M stage) and a DMA/loader port used for bulk memory initialisation and debug readout. It issues one word access per cycle to the synchronous data RAM, returns read data one cycle later to the winning requester, and produces a stall signal that freezes the CPU pipeline while the CPU is denied access.

---
 rtl/dmem_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - CPU/DMA arbiter for the single-port synchronous data RAM
// Optional DMEM_ARB_STARVE_EN: forced DMA grant after MAXWAIT consecutive denied cycles.
module dmem_bus_arbiter #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 13,
    parameter int DMEMWORDBITS = 2,
    parameter int MAXWAIT      = 4,
    parameter int MAXLOCK      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [DBITS-1:0]                     cpu_addr,
    input  logic [DBITS-1:0]                     cpu_wdata,
    output logic                                 cpu_gnt,
    output logic                                 cpu_stall,
    output logic                                 cpu_rvalid,
    output logic [DBITS-1:0]                     cpu_rdata,
    input  logic                                 dma_req,
    input  logic                                 dma_we,
    input  logic [DBITS-1:0]                     dma_addr,
    input  logic [DBITS-1:0]                     dma_wdata,
    output logic                                 dma_gnt,
    output logic                                 dma_rvalid,
    output logic [DBITS-1:0]                     dma_rdata,
    input  logic                                 dma_lock,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata
);

    localparam int WIDX = DMEMADDRBITS - DMEMWORDBITS;
    localparam int LCW  = $clog2(MAXLOCK + 1);
    localparam logic [DBITS-1:0] OOR_RDATA = DBITS'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_OWN    = 2'd1,
        DMA_OWN    = 2'd2,
        DMA_LOCKED = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [LCW-1:0] lock_cnt_q;
    logic [LCW-1:0] lock_cnt_d;
    logic           starve_hit;

    logic             any_gnt;
    logic             sel_we;
    logic             sel_oor;
    logic [DBITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_wdata;
    logic [WIDX-1:0]  last_addr_q;
    logic [DBITS-1:0] last_wdata_q;

    logic             rd_pending_q;
    logic             rd_dma_q;
    logic             rd_oor_q;
    logic [DBITS-1:0] ret_data;
    logic [DBITS-1:0] cpu_rdata_q;
    logic [DBITS-1:0] dma_rdata_q;
    logic             unused_offset_bits;

`ifdef DMEM_ARB_STARVE_EN
    localparam int SCW = $clog2(MAXWAIT + 1);

    logic [SCW-1:0] starve_cnt_q;

    assign starve_hit = (starve_cnt_q == SCW'(MAXWAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt_q <= '0;
        end else if (!starve_hit) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_maxwait = MAXWAIT;

    assign starve_hit = 1'b0;
`endif

    // State register: winner of the previous cycle plus length of the current lock run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next state: a lock run is counted in grants, so it never exceeds MAXLOCK cycles.
    always_comb begin
        state_d    = IDLE;
        lock_cnt_d = '0;
        if (dma_gnt) begin
            if (dma_lock && (lock_cnt_q < LCW'(MAXLOCK - 1))) begin
                state_d    = DMA_LOCKED;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                state_d = DMA_OWN;
            end
        end else if (cpu_gnt) begin
            state_d = CPU_OWN;
        end
    end

    // Grant outputs: combinational, at most one per cycle, none while in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if ((state_q == DMA_LOCKED) && dma_req) begin
                dma_gnt = 1'b1;
            end else if (starve_hit && dma_req) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    assign any_gnt   = cpu_gnt | dma_gnt;
    assign sel_addr  = cpu_gnt ? cpu_addr  : dma_addr;
    assign sel_we    = cpu_gnt ? cpu_we    : dma_we;
    assign sel_wdata = cpu_gnt ? cpu_wdata : dma_wdata;
    assign sel_oor   = |sel_addr[DBITS-1:DMEMADDRBITS];

    assign unused_offset_bits = ^sel_addr[DMEMWORDBITS-1:0];

    // Out-of-range accesses still consume the slot but never reach the RAM array.
    assign mem_we    = any_gnt & sel_we & ~sel_oor;
    assign mem_addr  = any_gnt ? sel_addr[DMEMADDRBITS-1:DMEMWORDBITS] : last_addr_q;
    assign mem_wdata = any_gnt ? sel_wdata : last_wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else if (any_gnt) begin
            last_addr_q  <= sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            last_wdata_q <= sel_wdata;
        end
    end

    // Read return tag: which port owns the data coming back from the RAM this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending_q <= 1'b0;
            rd_dma_q     <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            rd_pending_q <= any_gnt & ~sel_we;
            rd_dma_q     <= dma_gnt;
            rd_oor_q     <= sel_oor;
        end
    end

    assign ret_data   = rd_oor_q ? OOR_RDATA : mem_rdata;
    assign cpu_rvalid = rd_pending_q & ~rd_dma_q;
    assign dma_rvalid = rd_pending_q & rd_dma_q;
    assign cpu_rdata  = cpu_rvalid ? ret_data : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? ret_data : dma_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= ret_data;
            end
            if (dma_rvalid) begin
                dma_rdata_q <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - self-checking bench for dmem_bus_arbiter
// Directed scenarios then random traffic, each cycle compared to a rule-level model.
module tb_dmem_bus_arbiter;

    localparam int MAXWAIT = 4;
    localparam int MAXLOCK = 8;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif
    localparam logic [31:0] OOR_WORD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [31:0] dma_addr = '0;
    logic [31:0] dma_wdata = '0;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dma_lock = 1'b0;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    dmem_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_lock   (dma_lock),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // env_ram is the RAM the DUT talks to; model_ram is the model's own view of memory.
    logic [31:0] env_ram   [0:2047];
    logic [31:0] model_ram [0:2047];

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    int          m_win;
    bit          m_lockwin;
    int          m_lock_run;
    int          m_wait;
    int          m_last_idx;
    bit          m_rd_pending;
    bit          m_rd_dma;
    logic [31:0] m_rd_data;
    logic [31:0] m_cpu_hold;
    logic [31:0] m_dma_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win        = 0;
        m_lockwin    = 1'b0;
        m_lock_run   = 0;
        m_wait       = 0;
        m_last_idx   = 0;
        m_rd_pending = 1'b0;
        m_rd_dma     = 1'b0;
        m_rd_data    = '0;
        m_cpu_hold   = '0;
        m_dma_hold   = '0;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic lock);
        dma_req   = req;
        dma_we    = we;
        dma_addr  = addr;
        dma_wdata = wdata;
        dma_lock  = lock;
    endtask

    // One bus cycle: entered at posedge+1, checks mid-cycle, returns at the next posedge+1.
    task automatic cycle();
        bit          locked;
        bit          starve;
        bit          oor;
        bit          we;
        bit          e_we;
        bit          e_cpu_rv;
        bit          e_dma_rv;
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [10:0] s_addr;
        logic        s_we;
        logic [31:0] s_wdata;
        #4;
        locked = m_lockwin && (m_lock_run < MAXLOCK);
        starve = STARVE && (m_wait >= MAXWAIT);
        if (dma_req && (locked || starve)) m_win = 2;
        else if (cpu_req)                  m_win = 1;
        else if (dma_req)                  m_win = 2;
        else                               m_win = 0;
        addr  = (m_win == 1) ? cpu_addr  : dma_addr;
        we    = (m_win == 1) ? cpu_we    : dma_we;
        wdata = (m_win == 1) ? cpu_wdata : dma_wdata;
        oor   = (addr >> 13) != 0;
        idx   = int'((addr % 8192) / 4);
        e_we  = (m_win != 0) && we && !oor;
        e_cpu_rv = m_rd_pending && !m_rd_dma;
        e_dma_rv = m_rd_pending && m_rd_dma;

        chk("cpu_gnt", 32'(cpu_gnt), 32'(m_win == 1));
        chk("dma_gnt", 32'(dma_gnt), 32'(m_win == 2));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && (m_win != 1)));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), (m_win != 0) ? idx : m_last_idx);
        if (e_we) chk("mem_wdata", mem_wdata, wdata);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cpu_rv));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(e_dma_rv));
        chk("cpu_rdata", cpu_rdata, e_cpu_rv ? m_rd_data : m_cpu_hold);
        chk("dma_rdata", dma_rdata, e_dma_rv ? m_rd_data : m_dma_hold);

        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;

        if (e_cpu_rv) m_cpu_hold = m_rd_data;
        if (e_dma_rv) m_dma_hold = m_rd_data;
        m_rd_pending = (m_win != 0) && !we;
        m_rd_dma     = (m_win == 2);
        m_rd_data    = oor ? OOR_WORD : model_ram[idx];
        if (m_win != 0) m_last_idx = idx;
        if (e_we) model_ram[idx] = wdata;
        if ((m_win == 2) && dma_lock) begin
            m_lock_run = locked ? m_lock_run + 1 : 1;
            m_lockwin  = 1'b1;
        end else begin
            m_lock_run = 0;
            m_lockwin  = 1'b0;
        end
        if (dma_req && (m_win != 2)) m_wait = (m_wait < MAXWAIT) ? m_wait + 1 : MAXWAIT;
        else                         m_wait = 0;

        @(posedge clk);
        #1;
        mem_rdata = env_ram[s_addr];
        if (s_we) env_ram[s_addr] = s_wdata;
    endtask

    task automatic do_reset(input int cycles);
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        #1;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
        chk("rst_dma_gnt", 32'(dma_gnt), 0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(9))
            0:       a = 32'hF000_0000 | {26'b0, 4'($urandom_range(15)), 2'b00};
            1:       a = 32'h0000_1FFC;
            2:       a = 32'h0000_2000;
            default: a = {26'b0, 4'($urandom_range(15)), 2'($urandom_range(3))};
        endcase
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) begin
            env_ram[i]   = $urandom;
            model_ram[i] = env_ram[i];
        end
        env_ram[16]   = 32'h0000_1234;
        model_ram[16] = 32'h0000_1234;
        model_reset();
        do_reset(2);

        // CPU read of 0x40 returns the RAM word one cycle later
        set_cpu(1'b1, 1'b0, 32'h40, '0);
        cycle();
        set_cpu(1'b0, 1'b0, '0, '0);
        #1;
        chk("tp_cpu_rdata", cpu_rdata, 32'h0000_1234);
        chk("tp_cpu_rvalid", 32'(cpu_rvalid), 1);
        cycle();

        // Both ports requesting continuously
        set_dma(1'b1, 1'b0, 32'h80, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            set_cpu(1'b1, 1'b0, 32'(i * 4), '0);
            cycle();
        end
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        cycle();

        // DMA lock run while the CPU keeps requesting
        set_dma(1'b1, 1'b0, 32'h200, '0, 1'b1);
        cycle();
        set_cpu(1'b1, 1'b0, 32'h44, '0);
        for (int i = 0; i < 10; i++) cycle();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        cycle();

        // Out-of-range and top-of-range addresses
        set_cpu(1'b1, 1'b1, 32'hF000_0000, 32'h5555_AAAA);
        cycle();
        set_cpu(1'b1, 1'b0, 32'hF000_0000, '0);
        cycle();
        set_cpu(1'b1, 1'b1, 32'h0000_1FFC, 32'h0000_0077);
        cycle();
        set_cpu(1'b1, 1'b0, 32'h0000_1FFC, '0);
        cycle();
        set_cpu(1'b1, 1'b0, 32'h0000_2000, '0);
        cycle();
        set_cpu(1'b0, 1'b0, '0, '0);
        cycle();

        // DMA write then CPU read of the same word
        set_dma(1'b1, 1'b1, 32'h100, 32'h0000_CAFE, 1'b0);
        cycle();
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        set_cpu(1'b1, 1'b0, 32'h100, '0);
        cycle();
        set_cpu(1'b0, 1'b0, '0, '0);
        cycle();

        // Reset the cycle after a granted, locking DMA read
        set_dma(1'b1, 1'b0, 32'h300, '0, 1'b1);
        cycle();
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_drops_dma_rvalid", 32'(dma_rvalid), 0);
        do_reset(2);
        cycle();
        set_cpu(1'b1, 1'b0, 32'h08, '0);
        set_dma(1'b1, 1'b0, 32'h0C, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        cycle();

        // Random traffic; each requester holds its request until granted
        for (int i = 0; i < 600; i++) begin
            if (!cpu_req && ($urandom_range(3) != 0))
                set_cpu(1'b1, 1'($urandom_range(1)), rand_addr(), $urandom);
            if (!dma_req && ($urandom_range(2) == 0))
                set_dma(1'b1, 1'($urandom_range(1)), rand_addr(), $urandom, dma_lock);
            dma_lock = ($urandom_range(2) != 0);
            cycle();
            if (m_win == 1) cpu_req = 1'b0;
            if (m_win == 2) dma_req = 1'b0;
        end
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
